// File: rtl/id_issue_ctrl.sv
// Single-entry issue stage between decode and ALU with a 32-entry register scoreboard.
// Optional macro ISSUE_WB_BYPASS_EN: same-cycle writeback wakes a stalled entry.
module id_issue_ctrl #(
  parameter int ALU_W       = 4,
  parameter int XLEN        = 32,
  parameter int NOP_CODE    = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALU_W-1:0]       in_alu_type,
  input  logic                   in_wr_tag,
  input  logic                   in_imm_tag,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [ALU_W-1:0]       issue_alu_type,
  output logic                   issue_wr_tag,
  output logic                   issue_imm_tag,
  output logic [XLEN-1:0]        issue_imm,
  output logic [4:0]             issue_rd,
  output logic [4:0]             issue_rs1,
  output logic [4:0]             issue_rs2,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [1:0]             dbg_state,
  output logic [31:0]            dbg_busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a presented issue_* payload holds
  // until it transfers.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                 state;
  logic                   hold_valid;
  logic                   ready_en;
  logic [31:0]            busy_q;
  logic [31:0]            busy_view;
  logic [31:0]            busy_next;
  logic                   hazard;
  logic                   is_nop;
  logic                   fire;
  logic                   nop_drop;
  logic                   load;
  logic                   hold_next;
  logic [STALL_CNT_W-1:0] stall_next;

  // Busy bits seen by the hazard check; the bypass build hides a register being
  // written back this very cycle.
  always_comb begin
    busy_view = busy_q;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid) busy_view[wb_rd] = 1'b0;
`endif
    busy_view[0] = 1'b0;
  end

  always_comb begin
    hazard     = 1'b0;
    is_nop     = 1'b0;
    state      = ST_EMPTY;
    issue_valid = 1'b0;
    fire       = 1'b0;
    nop_drop   = 1'b0;
    in_ready   = 1'b0;
    load       = 1'b0;
    hold_next  = hold_valid;
    busy_next  = busy_q;
    stall_next = stall_cycles;

    hazard = (issue_rs1 != 5'd0 && busy_view[issue_rs1]) ||
             (!issue_imm_tag && issue_rs2 != 5'd0 && busy_view[issue_rs2]) ||
             (issue_wr_tag && issue_rd != 5'd0 && busy_view[issue_rd]);
    is_nop = (issue_alu_type == ALU_W'(NOP_CODE));

    if (!hold_valid)  state = ST_EMPTY;
    else if (hazard)  state = ST_STALL;
    else              state = ST_HOLD;

    issue_valid = hold_valid && !hazard && !is_nop;
    fire        = issue_valid && issue_ready;
    nop_drop    = hold_valid && is_nop;
    in_ready    = ready_en && !flush && (!hold_valid || fire || nop_drop);
    load        = in_valid && in_ready;

    if (load)                 hold_next = 1'b1;
    else if (fire || nop_drop) hold_next = 1'b0;

    // Clear first so a same-cycle issue to the same register stays busy.
    if (wb_valid)                           busy_next[wb_rd]    = 1'b0;
    if (fire && issue_wr_tag)               busy_next[issue_rd] = 1'b1;
    if (flush) begin
      busy_next = '0;
      hold_next = 1'b0;
    end
    busy_next[0] = 1'b0;

    if (state == ST_STALL && stall_cycles != {STALL_CNT_W{1'b1}})
      stall_next = stall_cycles + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid     <= 1'b0;
      ready_en       <= 1'b0;
      busy_q         <= '0;
      stall_cycles   <= '0;
      issue_alu_type <= '0;
      issue_wr_tag   <= 1'b0;
      issue_imm_tag  <= 1'b0;
      issue_imm      <= '0;
      issue_rd       <= '0;
      issue_rs1      <= '0;
      issue_rs2      <= '0;
    end else begin
      hold_valid   <= hold_next;
      ready_en     <= 1'b1;
      busy_q       <= busy_next;
      stall_cycles <= stall_next;
      if (load) begin
        issue_alu_type <= in_alu_type;
        issue_wr_tag   <= in_wr_tag;
        issue_imm_tag  <= in_imm_tag;
        issue_imm      <= in_imm;
        issue_rd       <= in_rd;
        issue_rs1      <= in_rs1;
        issue_rs2      <= in_rs2;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_busy  = busy_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus a randomized run
// against a scoreboard-style reference model of the issue rules.
module tb_id_issue_ctrl;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam int EW = 53;

  typedef struct packed {
    logic [3:0]  alu;
    logic        wr;
    logic        imm_tag;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_type;
  logic        in_wr_tag;
  logic        in_imm_tag;
  logic [31:0] in_imm;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_alu_type;
  logic        issue_wr_tag;
  logic        issue_imm_tag;
  logic [31:0] issue_imm;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cycles;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_valid;
  bit              m_ready_en;
  entry_t          m_e;
  bit              m_busy[32];
  int              m_stall;
  logic [EW-1:0]   exp_q[$];

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_type(in_alu_type), .in_wr_tag(in_wr_tag), .in_imm_tag(in_imm_tag),
    .in_imm(in_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_type(issue_alu_type), .issue_wr_tag(issue_wr_tag),
    .issue_imm_tag(issue_imm_tag), .issue_imm(issue_imm),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state), .dbg_busy(dbg_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_reg_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid && wb_rd == r) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  function automatic bit m_hazard();
    return m_reg_busy(m_e.rs1) ||
           (!m_e.imm_tag && m_reg_busy(m_e.rs2)) ||
           (m_e.wr && m_reg_busy(m_e.rd));
  endfunction

  function automatic bit m_issue_valid();
    return m_valid && !m_hazard() && m_e.alu != NOP;
  endfunction

  function automatic bit m_fire();
    return m_issue_valid() && issue_ready;
  endfunction

  function automatic bit m_in_ready();
    return m_ready_en && !flush &&
           (!m_valid || m_fire() || (m_valid && m_e.alu == NOP));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    m_valid    = 1'b0;
    m_ready_en = 1'b0;
    m_stall    = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    exp_q.delete();
  endtask

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    bit     fire, nop, rdy, stalled, accept;
    entry_t in_e;
    fire    = m_fire();
    nop     = m_valid && m_e.alu == NOP;
    rdy     = m_in_ready();
    stalled = m_valid && m_hazard();
    accept  = in_valid && rdy;
    in_e    = '{in_alu_type, in_wr_tag, in_imm_tag, in_imm, in_rd, in_rs1, in_rs2};
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      m_ready_en = 1'b1;
      if (stalled && m_stall < 65535) m_stall++;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
      end else begin
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        if (fire && m_e.wr && m_e.rd != 0) m_busy[m_e.rd] = 1'b1;
        if (fire && exp_q.size() > 0) void'(exp_q.pop_front());
        if (accept) begin
          m_valid = 1'b1;
          m_e     = in_e;
          if (in_e.alu != NOP) exp_q.push_back(in_e);
        end else if (fire || nop) begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_alu_type = NOP;
    in_wr_tag   = 1'b0;
    in_imm_tag  = 1'b0;
    in_imm      = '0;
    in_rd       = '0;
    in_rs1      = '0;
    in_rs2      = '0;
    issue_ready = 1'b1;
    wb_valid    = 1'b0;
    wb_rd       = '0;
  endtask

  task automatic drv(input logic [3:0] alu, input logic wr, input logic it,
                     input logic [31:0] imm, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid    = 1'b1;
    in_alu_type = alu;
    in_wr_tag   = wr;
    in_imm_tag  = it;
    in_imm      = imm;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    checks++; if (dbg_busy !== 32'd0 || issue_imm !== 32'd0 || issue_rd !== 5'd0) begin
      errors++; $display("FAIL reset_state: busy %h imm %h rd %0d want all 0", dbg_busy, issue_imm, issue_rd);
    end
    #10;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_raw();
    int exp_stall;
    idle_inputs();
    drv(ADD, 1'b1, 1'b1, 32'd5, 5'd1, 5'd0, 5'd0);   // addi x1,x0,5
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_accept: in_ready got %0b want 1", in_ready); end
    tick();
    drv(ADD, 1'b1, 1'b0, 32'd0, 5'd2, 5'd1, 5'd1);   // add x2,x1,x1
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd1 || issue_imm !== 32'd5) begin
      errors++; $display("FAIL raw_addi_issue: valid %0b rd %0d imm %0d want 1/1/5", issue_valid, issue_rd, issue_imm);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (dbg_busy[1] !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL raw_stall_enter: busy1 %0b valid %0b want 1/0", dbg_busy[1], issue_valid);
    end
    tick();
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL raw_stall_cnt1: got %0d want 1", stall_cycles); end
    tick();
    checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL raw_stall_cnt2: got %0d want 2", stall_cycles); end
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    #1;
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd2) begin
      errors++; $display("FAIL raw_wb_same_cycle: valid %0b rd %0d want 1/2", issue_valid, issue_rd);
    end
    exp_stall = 2;
`else
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL raw_wb_same_cycle: valid %0b want 0", issue_valid); end
    exp_stall = 3;
`endif
    tick();
    wb_valid = 1'b0;
    #1;
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (issue_valid !== 1'b0 || dbg_busy[2] !== 1'b1) begin
      errors++; $display("FAIL raw_wb_next: valid %0b busy2 %0b want 0/1", issue_valid, dbg_busy[2]);
    end
`else
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd2) begin
      errors++; $display("FAIL raw_wb_next: valid %0b rd %0d want 1/2", issue_valid, issue_rd);
    end
`endif
    checks++; if (stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL raw_stall_total: got %0d want %0d", stall_cycles, exp_stall);
    end
    idle(2);
  endtask

  task automatic test_stream();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      drv(SUB, 1'b1, 1'b0, 32'd0, 5'(3 + i), 5'd0, 5'd0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); end
      if (i > 0) begin
        checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'(2 + i)) begin
          errors++; $display("FAIL stream_issue[%0d]: valid %0b rd %0d want 1/%0d", i, issue_valid, issue_rd, 2 + i);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd6) begin
      errors++; $display("FAIL stream_last: valid %0b rd %0d want 1/6", issue_valid, issue_rd);
    end
    tick();
    checks++; if (dbg_busy[6:3] !== 4'hf) begin errors++; $display("FAIL stream_busy: got %h want f", dbg_busy[6:3]); end
  endtask

  task automatic test_backpressure();
    idle(1);
    drv(SUB, 1'b1, 1'b1, 32'h1234, 5'd8, 5'd0, 5'd0);
    tick();
    drv(ADD, 1'b1, 1'b1, 32'd77, 5'd9, 5'd0, 5'd0);
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || in_ready !== 1'b0 || issue_rd !== 5'd8 ||
                    issue_imm !== 32'h1234 || issue_alu_type !== SUB) begin
        errors++; $display("FAIL bp_hold[%0d]: valid %0b ready %0b rd %0d imm %h want 1/0/8/1234",
                           i, issue_valid, in_ready, issue_rd, issue_imm);
      end
      tick();
    end
    issue_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd9 || issue_imm !== 32'd77) begin
      errors++; $display("FAIL bp_next: valid %0b rd %0d imm %0d want 1/9/77", issue_valid, issue_rd, issue_imm);
    end
    tick();
    checks++; if (dbg_busy[9:8] !== 2'b11) begin errors++; $display("FAIL bp_busy: got %b want 11", dbg_busy[9:8]); end
  endtask

  task automatic test_nop();
    idle(1);
    drv(NOP, 1'b1, 1'b0, 32'd0, 5'd7, 5'd0, 5'd0);
    tick();
    drv(ADD, 1'b1, 1'b1, 32'd3, 5'd10, 5'd0, 5'd0);
    #1;
    checks++; if (issue_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL nop_drop: valid %0b ready %0b want 0/1", issue_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd10 || dbg_busy[7] !== 1'b0) begin
      errors++; $display("FAIL nop_next: valid %0b rd %0d busy7 %0b want 1/10/0", issue_valid, issue_rd, dbg_busy[7]);
    end
    tick();
  endtask

  task automatic test_flush();
    idle(1);
    wb_valid = 1'b1;   // x1 may still be busy from earlier; start clean
    wb_rd    = 5'd1;
    tick();
    wb_valid = 1'b0;
    drv(ADD, 1'b1, 1'b1, 32'd1, 5'd1, 5'd0, 5'd0);
    tick();
    drv(ADD, 1'b1, 1'b1, 32'd0, 5'd11, 5'd1, 5'd0);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0 || dbg_busy[1] !== 1'b1) begin
      errors++; $display("FAIL flush_pre: valid %0b busy1 %0b want 0/1", issue_valid, dbg_busy[1]);
    end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (dbg_busy !== 32'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_post: busy %h valid %0b ready %0b want 0/0/1", dbg_busy, issue_valid, in_ready);
    end
  endtask

  task automatic test_random();
    entry_t f;
    for (int n = 0; n < 400; n++) begin
      flush       = ($urandom_range(0, 39) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_alu_type = ($urandom_range(0, 7) == 0) ? NOP : 4'($urandom_range(1, 15));
      in_wr_tag   = 1'($urandom_range(0, 1));
      in_imm_tag  = 1'($urandom_range(0, 1));
      in_imm      = $urandom;
      in_rd       = 5'($urandom_range(0, 7));
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      #1;
      checks++; if (in_ready !== m_in_ready()) begin
        errors++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", n, in_ready, m_in_ready());
      end
      checks++; if (issue_valid !== m_issue_valid()) begin
        errors++; $display("FAIL rnd_issue_valid[%0d]: got %0b want %0b", n, issue_valid, m_issue_valid());
      end
      checks++; if (dbg_busy !== m_busy_vec()) begin
        errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, dbg_busy, m_busy_vec());
      end
      checks++; if (stall_cycles !== 16'(m_stall)) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, stall_cycles, m_stall);
      end
      if (m_fire()) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_fire_q[%0d]: got fire, want queued entry", n);
        end else begin
          f = entry_t'(exp_q[0]);
          if ({issue_alu_type, issue_wr_tag, issue_imm_tag, issue_imm, issue_rd, issue_rs1, issue_rs2} !== f) begin
            errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", n,
              {issue_alu_type, issue_wr_tag, issue_imm_tag, issue_imm, issue_rd, issue_rs1, issue_rs2}, f);
          end
        end
      end
      tick();
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drv(ADD, 1'b1, 1'b1, 32'd9, 5'd1, 5'd0, 5'd0);
    tick();
    drv(SUB, 1'b1, 1'b0, 32'd0, 5'd12, 5'd1, 5'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (issue_valid !== 1'b0 || stall_cycles !== 16'(m_stall)) begin
      errors++; $display("FAIL mid_stall: valid %0b stall %0d want 0/%0d", issue_valid, stall_cycles, m_stall);
    end
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (in_ready !== 1'b0 || issue_valid !== 1'b0 || issue_rd !== 5'd0 || issue_rs1 !== 5'd0 ||
                  issue_alu_type !== 4'd0 || stall_cycles !== 16'd0 || dbg_busy !== 32'd0) begin
      errors++; $display("FAIL mid_reset: ready %0b valid %0b rd %0d rs1 %0d stall %0d busy %h want all 0",
                         in_ready, issue_valid, issue_rd, issue_rs1, stall_cycles, dbg_busy);
    end
    #10;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release: in_ready got %0b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_stream();
    test_backpressure();
    test_nop();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
